// File: rtl/icache_ctrl_if.sv
// rtl/icache_ctrl_if.sv - I-cache controller bus bundle: IF req/resp, CACHE-op invalidate, tag/data RAM ports, AXI read channels
interface icache_ctrl_if;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        inv_valid;
    logic [6:0]  inv_index;
    logic        inv_ready;
    logic        tag_en;
    logic        tag_wen;
    logic [6:0]  tag_index;
    logic [20:0] tag_wdata;
    logic [20:0] tag_rdata;
    logic        data_en;
    logic        data_we;
    logic [6:0]  data_index;
    logic [2:0]  data_word;
    logic [31:0] data_wdata;
    logic [31:0] data_rdata;
    logic        ar_valid;
    logic        ar_ready;
    logic [31:0] ar_addr;
    logic [7:0]  ar_len;
    logic [2:0]  ar_size;
    logic [1:0]  ar_burst;
    logic        r_valid;
    logic        r_ready;
    logic [31:0] r_data;
    logic        r_last;
    logic [31:0] perf_hit_cnt;
    logic [31:0] perf_miss_cnt;

    modport master (
        input  req_valid, req_addr, inv_valid, inv_index, tag_rdata, data_rdata,
               ar_ready, r_valid, r_data, r_last,
        output req_ready, resp_valid, resp_data, inv_ready, tag_en, tag_wen, tag_index,
               tag_wdata, data_en, data_we, data_index, data_word, data_wdata,
               ar_valid, ar_addr, ar_len, ar_size, ar_burst, r_ready,
               perf_hit_cnt, perf_miss_cnt
    );

    modport slave (
        output req_valid, req_addr, inv_valid, inv_index, tag_rdata, data_rdata,
               ar_ready, r_valid, r_data, r_last,
        input  req_ready, resp_valid, resp_data, inv_ready, tag_en, tag_wen, tag_index,
               tag_wdata, data_en, data_we, data_index, data_word, data_wdata,
               ar_valid, ar_addr, ar_len, ar_size, ar_burst, r_ready,
               perf_hit_cnt, perf_miss_cnt
    );
endinterface

// File: rtl/icache_ctrl.sv
// rtl/icache_ctrl.sv - direct-mapped I-cache sequencer (invalidate sweep, lookup, 8-beat refill); optional ICACHE_PERF_CNT_EN hit/miss counters
module icache_ctrl #(
    parameter int SETS     = 128,
    parameter int LINE_WDS = 8
) (
    input  logic          clk,
    input  logic          resetn,
    icache_ctrl_if.master bus
);
    typedef enum logic [2:0] {
        S_INIT, S_IDLE, S_LOOKUP, S_MISS_AR, S_REFILL, S_TAG_WR
    } state_t;

    state_t      state_q, state_d;
    logic [6:0]  sweep_q, sweep_d;
    logic [31:2] addr_q, addr_d;
    logic [2:0]  beat_q, beat_d;
    logic [31:0] crit_q, crit_d;
    logic        lookup_hit;

    assign lookup_hit   = bus.tag_rdata[20] && (bus.tag_rdata[19:0] == addr_q[31:12]);
    assign bus.ar_len   = 8'(LINE_WDS - 1);
    assign bus.ar_size  = 3'd2;
    assign bus.ar_burst = 2'b01;

    // State and datapath registers; reset restarts the invalidate sweep from set 0
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_INIT;
            sweep_q <= '0;
            addr_q  <= '0;
            beat_q  <= '0;
            crit_q  <= '0;
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
            addr_q  <= addr_d;
            beat_q  <= beat_d;
            crit_q  <= crit_d;
        end
    end

    // Next-state and RAM/bus outputs; everything held quiet while reset is asserted
    always_comb begin
        state_d        = state_q;
        sweep_d        = sweep_q;
        addr_d         = addr_q;
        beat_d         = beat_q;
        crit_d         = crit_q;
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        bus.resp_data  = '0;
        bus.inv_ready  = 1'b0;
        bus.tag_en     = 1'b0;
        bus.tag_wen    = 1'b0;
        bus.tag_index  = '0;
        bus.tag_wdata  = '0;
        bus.data_en    = 1'b0;
        bus.data_we    = 1'b0;
        bus.data_index = '0;
        bus.data_word  = '0;
        bus.data_wdata = '0;
        bus.ar_valid   = 1'b0;
        bus.ar_addr    = '0;
        bus.r_ready    = 1'b0;
        if (resetn) begin
            case (state_q)
                S_INIT: begin
                    bus.tag_en    = 1'b1;
                    bus.tag_wen   = 1'b1;
                    bus.tag_index = sweep_q;
                    sweep_d       = sweep_q + 7'd1;
                    if (sweep_q == 7'(SETS - 1)) state_d = S_IDLE;
                end
                S_IDLE: begin
                    if (bus.inv_valid) begin
                        // invalidate wins over a fetch arriving in the same cycle
                        bus.inv_ready = 1'b1;
                        bus.tag_en    = 1'b1;
                        bus.tag_wen   = 1'b1;
                        bus.tag_index = bus.inv_index;
                    end else begin
                        bus.req_ready = 1'b1;
                        if (bus.req_valid) begin
                            bus.tag_en     = 1'b1;
                            bus.tag_index  = bus.req_addr[11:5];
                            bus.data_en    = 1'b1;
                            bus.data_index = bus.req_addr[11:5];
                            bus.data_word  = bus.req_addr[4:2];
                            addr_d         = bus.req_addr[31:2];
                            state_d        = S_LOOKUP;
                        end
                    end
                end
                S_LOOKUP: begin
                    if (lookup_hit) begin
                        bus.resp_valid = 1'b1;
                        bus.resp_data  = bus.data_rdata;
                        state_d        = S_IDLE;
                    end else begin
                        state_d = S_MISS_AR;
                    end
                end
                S_MISS_AR: begin
                    bus.ar_valid = 1'b1;
                    bus.ar_addr  = {addr_q[31:5], 5'b0};
                    if (bus.ar_ready) state_d = S_REFILL;
                end
                S_REFILL: begin
                    bus.r_ready = 1'b1;
                    if (bus.r_valid) begin
                        bus.data_en    = 1'b1;
                        bus.data_we    = 1'b1;
                        bus.data_index = addr_q[11:5];
                        bus.data_word  = beat_q;
                        bus.data_wdata = bus.r_data;
                        beat_d         = beat_q + 3'd1;
                        if (beat_q == addr_q[4:2]) crit_d = bus.r_data;
                        if (bus.r_last) begin
                            beat_d  = '0;
                            state_d = S_TAG_WR;
                        end
                    end
                end
                S_TAG_WR: begin
                    bus.tag_en     = 1'b1;
                    bus.tag_wen    = 1'b1;
                    bus.tag_index  = addr_q[11:5];
                    bus.tag_wdata  = {1'b1, addr_q[31:12]};
                    bus.resp_valid = 1'b1;
                    bus.resp_data  = crit_q;
                    state_d        = S_IDLE;
                end
                default: state_d = S_INIT;
            endcase
        end
    end

`ifdef ICACHE_PERF_CNT_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;

    // Count every lookup outcome; both counters wrap at 32 bits
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (state_q == S_LOOKUP) begin
            if (lookup_hit) hit_cnt_q  <= hit_cnt_q + 32'd1;
            else            miss_cnt_q <= miss_cnt_q + 32'd1;
        end
    end

    assign bus.perf_hit_cnt  = hit_cnt_q;
    assign bus.perf_miss_cnt = miss_cnt_q;
`else
    assign bus.perf_hit_cnt  = '0;
    assign bus.perf_miss_cnt = '0;
`endif
endmodule
